pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 4: program counter width in bits, range 2..32.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: return-stack entries, power of two, range 2..16.
REQ-003 SHALL have parameter RESET_VEC, default 0: PC value loaded on reset, PC_W bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  holds the PC and stack this cycle.
REQ-007 halt  input  1  requests a transition to HALTED.
REQ-008 resume  input  1  requests a return from HALTED to RUN.
REQ-009 jump_en  input  1  absolute jump request.
REQ-010 jump_addr  input  PC_W  absolute jump target.
REQ-011 branch_en  input  1  relative branch request, taken when branch_taken=1.
REQ-012 branch_taken  input  1  branch condition result.
REQ-013 branch_off  input  PC_W  two's-complement branch offset.
REQ-014 call_en  input  1  subroutine call; the target is jump_addr.
REQ-015 ret_en  input  1  subroutine return.
REQ-016 pc  output  PC_W  current program counter, registered.
REQ-017 running  output  1  high when the FSM is in RUN.
REQ-018 stack_ovf  output  1  sticky flag: call issued while the stack was full.
REQ-019 stack_unf  output  1  sticky flag: return issued while the stack was empty.

Function
REQ-020 FSM states SHALL be RUN and HALTED; reset enters RUN.
REQ-021 In RUN, halt=1 SHALL move the FSM to HALTED at the next edge, and the PC update for that cycle SHALL still occur.
REQ-022 In HALTED, the PC and stack SHALL hold, all control inputs except resume SHALL be ignored, and resume=1 SHALL return the FSM to RUN at the next edge.
REQ-023 When halt and resume are both 1 in HALTED, the FSM SHALL stay in HALTED.
REQ-024 In RUN, the next PC SHALL be chosen by priority: stall > ret_en > call_en > jump_en > branch_en&&branch_taken > pc+1.
REQ-025 stall=1 SHALL hold the PC and stack; a halt request in the same cycle is still honoured.
REQ-026 call_en SHALL push pc+1 (mod 2^PC_W) and load jump_addr.
REQ-027 ret_en SHALL pop the top entry into the PC.
REQ-028 A taken branch SHALL load pc+branch_off, truncated to PC_W bits (mod 2^PC_W wrap).
REQ-029 Increment SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-030 A call with STACK_DEPTH entries occupied SHALL still load jump_addr, drop the return address, leave the stack unchanged, and set stack_ovf.
REQ-031 A return with the stack empty SHALL load pc+1, leave the stack unchanged, and set stack_unf.
REQ-032 Every PC change SHALL take effect one cycle after the request edge, with no combinational path from inputs to pc.
REQ-033 The sticky flags SHALL clear only on reset.

Reset
REQ-034 Asserting reset (reset=0) SHALL immediately set pc=RESET_VEC, running=1, stack_ovf=0, stack_unf=0, and stack count=0, independent of clk.
REQ-035 A reset mid-call or mid-halt SHALL discard all stack contents and pending requests.
REQ-036 Stack entry storage is not reset; the count alone defines validity.

Structure
REQ-037 The package pc_seq_pkg SHALL hold the FSM state encoding (RUN=0, HALTED=1) and the next-PC source select encoding (HOLD, RET, CALL, JUMP, BRANCH, INC).
REQ-038 The return stack SHALL be a sub-module pc_ret_stack (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty) with a registered count and a combinational dout of the top entry.
REQ-039 The next-PC mux and the FSM SHALL reside in pc_sequencer.

Verification
REQ-040 Reset release, PC_W=4, RESET_VEC=0, run 17 cycles -> pc sequence 0..15, then 0; no flags set.
REQ-041 At pc=3, call_en with jump_addr=9, then 2 increments, then ret_en -> pc 9, 10, 11, 4.
REQ-042 STACK_DEPTH=4: issue 5 nested calls -> stack_ovf=1 after the 5th; 4 returns restore the correct addresses; a 5th return sets stack_unf=1 and gives pc+1.
REQ-043 At pc=2, branch_off=4'hE with branch_taken=1 -> pc=0; stall with ret_en and jump_en asserted -> pc holds, stack count unchanged.
REQ-044 halt at pc=5 -> pc=6, running=0, holds while jump_en pulses; resume -> running=1 and increment resumes at 7.
REQ-045 Assert reset mid-cycle while HALTED with 2 stack entries -> pc=RESET_VEC immediately, running=1, and a subsequent ret_en sets stack_unf.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: FSM states and
// the next-PC source select used by the PC mux.
package pc_seq_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_t;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    RET    = 3'd1,
    CALL   = 3'd2,
    JUMP   = 3'd3,
    BRANCH = 3'd4,
    INC    = 3'd5
  } pc_src_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: registered occupancy count, unreset entry storage,
// and a combinational view of the top entry.
module pc_ret_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign count_m1 = count - CW'(1);
  assign wr_idx   = count[AW-1:0];
  assign top_idx  = count_m1[AW-1:0];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign dout     = mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count_m1;
    end
  end

  // Entries carry no reset; the count alone says which ones are valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/HALTED FSM, prioritised next-PC mux and
// a return stack with sticky overflow/underflow flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            branch_en,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_off,
  input  logic            call_en,
  input  logic            ret_en,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            stack_ovf,
  output logic            stack_unf
);

  seq_state_t      state, next_state;
  pc_src_t         src;
  logic [PC_W-1:0] pc_inc, pc_next, stack_top;
  logic            push, pop, full, empty, ovf_set, unf_set;

  assign pc_inc  = pc + PC_W'(1);
  assign running = (state == RUN);

  pc_ret_stack #(
    .WIDTH(PC_W),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (stack_top),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      pc        <= RESET_VEC;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      stack_ovf <= stack_ovf | ovf_set;
      stack_unf <= stack_unf | unf_set;
    end
  end

  // Halt is sampled even while stalled; HALTED only listens to resume.
  always_comb begin
    next_state = state;
    src        = HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (state)
      RUN: begin
        if (halt) next_state = HALTED;
        if (stall) begin
          src = HOLD;
        end else if (ret_en) begin
          if (empty) begin
            src     = INC;
            unf_set = 1'b1;
          end else begin
            src = RET;
            pop = 1'b1;
          end
        end else if (call_en) begin
          src = CALL;
          if (full) ovf_set = 1'b1;
          else      push    = 1'b1;
        end else if (jump_en) begin
          src = JUMP;
        end else if (branch_en && branch_taken) begin
          src = BRANCH;
        end else begin
          src = INC;
        end
      end
      HALTED: begin
        if (resume && !halt) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_next = pc;
    case (src)
      HOLD:    pc_next = pc;
      RET:     pc_next = stack_top;
      CALL:    pc_next = jump_addr;
      JUMP:    pc_next = jump_addr;
      BRANCH:  pc_next = pc + branch_off;
      INC:     pc_next = pc_inc;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters
// (PC_W=4, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic       jump_en = 1'b0, branch_en = 1'b0, branch_taken = 1'b0;
  logic       call_en = 1'b0, ret_en = 1'b0;
  logic [3:0] jump_addr = '0, branch_off = '0;
  logic [3:0] pc;
  logic       running, stack_ovf, stack_unf;

  int tests_run = 0;
  int tests_failed = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .branch_en   (branch_en),
    .branch_taken(branch_taken),
    .branch_off  (branch_off),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .pc          (pc),
    .running     (running),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of control inputs (opcode string), clock it, then idle them.
  task automatic applyStimulus(input string op, input logic [3:0] addr = 4'd0, input logic [3:0] off = 4'd0);
    stall = 0; halt = 0; resume = 0; jump_en = 0; branch_en = 0;
    branch_taken = 0; call_en = 0; ret_en = 0;
    jump_addr = addr; branch_off = off;
    case (op)
      "inc":      ;
      "call":     call_en = 1;
      "ret":      ret_en = 1;
      "jump":     jump_en = 1;
      "br":       begin branch_en = 1; branch_taken = 1; end
      "brnt":     branch_en = 1;
      "stallmix": begin stall = 1; ret_en = 1; jump_en = 1; end
      "halt":     halt = 1;
      "resume":   resume = 1;
      "haltres":  begin halt = 1; resume = 1; end
      default:    $display("[TB] unknown op %s", op);
    endcase
    @(posedge clk);
    #1;
    stall = 0; halt = 0; resume = 0; jump_en = 0; branch_en = 0;
    branch_taken = 0; call_en = 0; ret_en = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_running", 32'(running), 32'h1);
    checkOutput("rst_ovf", 32'(stack_ovf), 32'h0);
    checkOutput("rst_unf", 32'(stack_unf), 32'h0);
    reset = 1'b1;

    // Free-running count 0..15 then wrap to 0
    checkOutput("seq_pc0", 32'(pc), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus("inc");
      checkOutput($sformatf("seq_pc%0d", i), 32'(pc), 32'(i % 16));
    end
    checkOutput("seq_ovf", 32'(stack_ovf), 32'h0);
    checkOutput("seq_unf", 32'(stack_unf), 32'h0);

    // Call / return round trip from pc=3
    repeat (3) applyStimulus("inc");
    checkOutput("pre_call_pc", 32'(pc), 32'h3);
    applyStimulus("call", 4'd9);
    checkOutput("call_pc", 32'(pc), 32'h9);
    applyStimulus("inc");
    checkOutput("sub_inc1", 32'(pc), 32'hA);
    applyStimulus("inc");
    checkOutput("sub_inc2", 32'(pc), 32'hB);
    applyStimulus("ret");
    checkOutput("ret_pc", 32'(pc), 32'h4);

    // Nested calls past the stack depth, then unwind past empty
    applyStimulus("call", 4'd2);
    applyStimulus("call", 4'd6);
    applyStimulus("call", 4'd10);
    applyStimulus("call", 4'd12);
    checkOutput("call4_pc", 32'(pc), 32'hC);
    checkOutput("call4_ovf", 32'(stack_ovf), 32'h0);
    applyStimulus("call", 4'd14);
    checkOutput("call5_pc", 32'(pc), 32'hE);
    checkOutput("call5_ovf", 32'(stack_ovf), 32'h1);
    applyStimulus("ret");
    checkOutput("ret1_pc", 32'(pc), 32'hB);
    applyStimulus("ret");
    checkOutput("ret2_pc", 32'(pc), 32'h7);
    applyStimulus("ret");
    checkOutput("ret3_pc", 32'(pc), 32'h3);
    applyStimulus("ret");
    checkOutput("ret4_pc", 32'(pc), 32'h5);
    checkOutput("ret4_unf", 32'(stack_unf), 32'h0);
    applyStimulus("ret");
    checkOutput("ret5_pc", 32'(pc), 32'h6);
    checkOutput("ret5_unf", 32'(stack_unf), 32'h1);

    // Branch wrap, untaken branch, stall priority
    applyStimulus("jump", 4'd2);
    checkOutput("jump_pc", 32'(pc), 32'h2);
    applyStimulus("br", 4'd0, 4'hE);
    checkOutput("br_wrap_pc", 32'(pc), 32'h0);
    applyStimulus("brnt", 4'd0, 4'h5);
    checkOutput("br_nt_pc", 32'(pc), 32'h1);
    applyStimulus("call", 4'd8);
    checkOutput("call8_pc", 32'(pc), 32'h8);
    applyStimulus("stallmix", 4'd3);
    checkOutput("stall_pc", 32'(pc), 32'h8);
    applyStimulus("ret");
    checkOutput("stall_ret_pc", 32'(pc), 32'h2);
    checkOutput("stall_ovf", 32'(stack_ovf), 32'h1);

    // Halt / resume with two entries left on the stack
    applyStimulus("call", 4'd7);
    applyStimulus("call", 4'd5);
    checkOutput("pre_halt_pc", 32'(pc), 32'h5);
    applyStimulus("halt");
    checkOutput("halt_pc", 32'(pc), 32'h6);
    checkOutput("halt_running", 32'(running), 32'h0);
    applyStimulus("jump", 4'd1);
    checkOutput("halt_jump_pc", 32'(pc), 32'h6);
    applyStimulus("haltres");
    checkOutput("haltres_running", 32'(running), 32'h0);
    checkOutput("haltres_pc", 32'(pc), 32'h6);
    applyStimulus("resume");
    checkOutput("resume_running", 32'(running), 32'h1);
    checkOutput("resume_pc", 32'(pc), 32'h6);
    applyStimulus("inc");
    checkOutput("resume_inc_pc", 32'(pc), 32'h7);

    // Asynchronous reset mid-cycle while halted
    applyStimulus("halt");
    checkOutput("halt2_running", 32'(running), 32'h0);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_pc", 32'(pc), 32'h0);
    checkOutput("async_running", 32'(running), 32'h1);
    checkOutput("async_ovf", 32'(stack_ovf), 32'h0);
    checkOutput("async_unf", 32'(stack_unf), 32'h0);
    #1 reset = 1'b1;
    applyStimulus("ret");
    checkOutput("post_rst_ret_pc", 32'(pc), 32'h1);
    checkOutput("post_rst_unf", 32'(stack_unf), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
